hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus. It holds a multi-digit hex value and walks a digit index across the bank. Each nibble is decoded through a single shared `hex_7seg` instance, and the controller drives the active-low anode of the digit whose slot is current. New display values arrive over a valid/ready load port and are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `NUM_DIGITS`, 4, number of digits scanned; legal range 1..8
- `CLK_DIV`, 50000, SHOW cycles per digit slot; must be ≥1
- `BLANK_CYCLES`, 500, anti-ghosting blank cycles before each SHOW; must be ≥1

- `clk` input 1: system clock
- `rst` input 1: synchronous, active-high reset
- `load_valid` input 1: load request
- `load_ready` output 1: controller can accept a load
- `load_data` input 4*NUM_DIGITS: nibble i drives digit i; digit 0 is least significant
- `digit_en` input NUM_DIGITS: per-digit enable, sampled live
- `seg_n` output 7: active-low segments, decoder bit order
- `an_n` output NUM_DIGITS: active-low anodes, at most one low at a time
- `frame_start` output 1: one-cycle pulse at the start of each frame

## Operation
- FSM has two states, BLANK and SHOW. The cycle counter counts 0..N-1 within a state.
- **BLANK:** `an_n` is all ones and `seg_n = 7'h7F`. After BLANK_CYCLES cycles the FSM moves to SHOW.
- **SHOW:** `an_n[idx]=0` if `digit_en[idx]`, else all ones. `seg_n` is the decoded nibble `disp[idx]`. After CLK_DIV cycles:
  - `idx` increments, wrapping from NUM_DIGITS-1 to 0.
  - FSM returns to BLANK.
- **Frame boundary:** the SHOW→BLANK transition in which `idx` wraps to 0.
  - If `pend_valid` is set: `disp <= pend` and `pend_valid <= 0`.
  - `frame_start` is high during the first BLANK cycle of digit 0, including the first BLANK after reset.
- **Load handshake:**
  - `load_ready = !pend_valid`, registered.
  - Accept occurs when `load_valid && load_ready`: `pend <= load_data`, `pend_valid <= 1`.
  - At most one load is pending. Further valid requests stall until the next boundary.
- **Simultaneous accept and commit:** impossible, because ready is low whenever a load is pending. A load accepted in the boundary cycle itself commits at the following boundary.
- **Disabled digit:** the digit still consumes its full slot time; its anode stays high.
- **Reset:** takes effect on any cycle, mid-slot or mid-load, and discards any pending load. Reset values:
  - FSM in BLANK, `idx=0`, counter 0
  - `disp=0`, `pend_valid=0`, `load_ready=1`
  - `seg_n=7'h7F`, `an_n` all ones, `frame_start=0`
- **Widths:**
  - Counter width is `$clog2(max(CLK_DIV,BLANK_CYCLES))`, with a minimum of 1.
  - `idx` width is `$clog2(NUM_DIGITS)`, with a minimum of 1.
  - No arithmetic is performed on nibbles.

## Timing
- `seg_n`, `an_n` and `frame_start` are registered and computed from next-state values. Outputs therefore change on the same edge as the state, with no 1-cycle skew between anode and segments.
- Frame length is `NUM_DIGITS*(BLANK_CYCLES+CLK_DIV)` cycles.
- The first SHOW of digit 0 starts BLANK_CYCLES cycles after the cycle in which `rst` is deasserted.
- Load-to-display latency runs from accept to the next boundary, up to one frame. It is never less than the remainder of the current frame.
- Any `load_data` value can be loaded; `hex_7seg` decodes every nibble, 0..F.

## Configuration
- `HEX_SCAN_LZ_BLANK_EN` — leading-zero suppression.
  - **Defined:** digits above the most significant nonzero nibble of `disp` output `seg_n=7'h7F` during their SHOW slot. Their anode still follows `digit_en`. Digit 0 is always shown, so a value of 0 displays "0".
  - **Undefined:** every digit shows its nibble.

## Structure
- `hex_scan_pkg` contains:
  - the state enum `{BLANK, SHOW}`
  - `SEG_OFF = 7'h7F`
  - the `seg_n`/`an_n` active-low polarity constants
- Sub-module: a single shared `hex_7seg` instance driven by `disp[idx_next]`.
- No other sub-modules. Counter, FSM and load register are inline.

## Test plan
Common configuration: NUM_DIGITS=4, CLK_DIV=4, BLANK_CYCLES=2, frame length 24 cycles.
- **Reset:** hold `rst` 3 cycles → `seg_n=7F`, `an_n=4'hF`, `load_ready=1`. First `an_n=4'hE` with `seg_n=7'h40` appears 2 cycles after release; `frame_start` pulses 1 cycle after release.
- **Scan order:** load `16'h1A3F`; after commit, successive SHOW slots give `an_n` E/D/B/7 with `seg_n` `0E`/`30`/`08`/`79`. Each slot lasts 4 cycles and is separated by 2 blank cycles.
- **Handshake stall:** accept `16'h1234` mid-frame, then hold `load_valid` with `16'h5678`. `load_ready` stays 0 until the boundary; "1234" displays first, then 5678 is accepted and shows one frame later.
- **Digit enable:** `digit_en=4'b1011` → `an_n` never equals `4'hB`, and the slot timing is unchanged at 24 cycles per frame.
- **Reset mid-operation:** assert `rst` during the digit-2 SHOW with a load pending. Afterward `disp=0`, the pending load is dropped, and scanning resumes at digit 0.
- **Leading-zero blanking (`HEX_SCAN_LZ_BLANK_EN`):**
  - Load `16'h0050` → digits 3 and 2 show `seg_n=7F`; digit 1 shows `12`; digit 0 shows `40`.
  - Load `16'h0000` → only digit 0 shows `40`.

Source files
------------

// File: rtl/hex_scan_pkg.sv
// Shared types and constants for the hex_scan_ctrl display scanner.
// Holds the scan state enum, the output polarity constants and a width helper.
package hex_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam logic       SEG_ACTIVE = 1'b0;
  localparam logic       AN_ACTIVE  = 1'b0;

  // Bits needed to hold 0..max(a,b)-1, never less than one.
  function automatic int width_min1(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/hex_7seg.sv
// Hex nibble to 7-segment decoder, active-high segments in {g,f,e,d,c,b,a} order.
// Every nibble 0..F has a glyph.
module hex_7seg (
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (nibble_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode hex digits on a shared segment bus.
// Optional leading-zero suppression is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_scan_ctrl
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_start
);

  localparam int CW = width_min1(CLK_DIV, BLANK_CYCLES);
  localparam int IW = width_min1(NUM_DIGITS, 1);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  scan_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  digits_t               disp_q, disp_d;
  digits_t               pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  ready_q;
  logic                  startup_q;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic                  fs_q, fs_d;

  logic                  boundary;
  logic                  accept;
  logic [6:0]            seg_on;
  logic                  lz_blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      startup_q    <= 1'b1;
      seg_n_q      <= SEG_OFF;
      an_n_q       <= {NUM_DIGITS{~AN_ACTIVE}};
      fs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      ready_q      <= ~pend_valid_d;
      startup_q    <= 1'b0;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      fs_q         <= fs_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    boundary = 1'b0;
    case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // Ready is low whenever a load is pending, so commit and accept never coincide.
  assign accept = load_valid && ready_q;

  always_comb begin
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (boundary && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end else if (accept) begin
      pend_d       = load_data;
      pend_valid_d = 1'b1;
    end
  end

  hex_7seg u_hex_7seg (
    .nibble_i (disp_q[idx_d]),
    .seg_o    (seg_on)
  );

`ifdef HEX_SCAN_LZ_BLANK_EN
  logic [IW-1:0] msd;

  // Digit 0 is never suppressed, so an all-zero value still reads "0".
  always_comb begin
    msd = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (disp_q[i] != 4'h0) begin
        msd = IW'(i);
      end
    end
  end

  assign lz_blank = (idx_d > msd);
`else
  assign lz_blank = 1'b0;
`endif

  always_comb begin
    seg_n_d = SEG_OFF;
    an_n_d  = {NUM_DIGITS{~AN_ACTIVE}};
    fs_d    = startup_q || boundary;
    if (state_d == SHOW) begin
      if (!lz_blank) begin
        seg_n_d = seg_on ^ {7{~SEG_ACTIVE}};
      end
      if (digit_en[idx_d]) begin
        an_n_d[idx_d] = AN_ACTIVE;
      end
    end
  end

  assign load_ready  = ready_q;
  assign seg_n       = seg_n_q;
  assign an_n        = an_n_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Scoreboard bench for hex_scan_ctrl (4 digits, 4 show cycles, 2 blank cycles).
// Expected outputs come from a frame-position model; HEX_SCAN_LZ_BLANK_EN selects suppression.
module tb_hex_scan_ctrl;

  localparam int ND    = 4;
  localparam int SHOWC = 4;
  localparam int BLNK  = 2;
  localparam int SLOT  = SHOWC + BLNK;
  localparam int FRAME = ND * SLOT;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  digit_en;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_start;

  exp_t        expq[$];
  int          checks;
  int          errors;
  int          k;
  logic [15:0] mdisp;
  logic [15:0] mpend;
  logic        mpv;
  logic        lastAccept;

  hex_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .CLK_DIV      (SHOWC),
    .BLANK_CYCLES (BLNK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .digit_en    (digit_en),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  // A digit is suppressed when it and everything above it are zero (digit 0 excepted).
  function automatic logic lzBlank(input logic [15:0] val, input int dig);
`ifdef HEX_SCAN_LZ_BLANK_EN
    return (dig > 0) && ((val >> (4 * dig)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Drives one cycle of inputs and queues the outputs expected after the next edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] d,
                               input logic [3:0] en);
    exp_t       e;
    int         p;
    int         dig;
    logic       readyBefore;
    logic [3:0] a;
    @(negedge clk);
    rst        = r;
    load_valid = v;
    load_data  = d;
    digit_en   = en;
    lastAccept = 1'b0;
    if (r) begin
      k     = 0;
      mdisp = 16'h0;
      mpv   = 1'b0;
      e.seg = 7'h7F;
      e.an  = 4'hF;
      e.fs  = 1'b0;
      e.rdy = 1'b1;
    end else begin
      readyBefore = !mpv;
      k = k + 1;
      p = k % FRAME;
      if (p == 0 && mpv) begin
        mdisp = mpend;
        mpv   = 1'b0;
      end else if (v && readyBefore) begin
        mpend      = d;
        mpv        = 1'b1;
        lastAccept = 1'b1;
      end
      dig   = p / SLOT;
      e.seg = 7'h7F;
      e.an  = 4'hF;
      e.fs  = (p == 0) || (k == 1);
      e.rdy = !mpv;
      if ((p % SLOT) >= BLNK) begin
        if (!lzBlank(mdisp, dig)) e.seg = decode(mdisp[dig*4 +: 4]);
        a = 4'hF;
        if (en[dig]) a[dig] = 1'b0;
        e.an = a;
      end
    end
    expq.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (seg_n !== e.seg || an_n !== e.an || frame_start !== e.fs || load_ready !== e.rdy) begin
      errors++;
      $display("[TB] FAIL outputs t=%0t got seg=%h an=%h fs=%b rdy=%b expected seg=%h an=%h fs=%b rdy=%b",
               $time, seg_n, an_n, frame_start, load_ready, e.seg, e.an, e.fs, e.rdy);
    end
  endtask

  task automatic idle(input int n, input logic [3:0] en);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 16'h0, en);
  endtask

  task automatic loadWait(input logic [15:0] d, input logic [3:0] en);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b1, d, en);
      n++;
    end while (!lastAccept && n < 4 * FRAME);
    checks++;
    if (!lastAccept) begin
      errors++;
      $display("[TB] FAIL load_accept_timeout data=%h cycles=%0d", d, n);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin
    checks     = 0;
    errors     = 0;
    k          = 0;
    mdisp      = 16'h0;
    mpend      = 16'h0;
    mpv        = 1'b0;
    lastAccept = 1'b0;
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0;
    digit_en   = 4'hF;

    repeat (3) applyStimulus(1'b1, 1'b0, 16'h0, 4'hF);
    idle(FRAME + 3, 4'hF);

    loadWait(16'h1A3F, 4'hF);
    idle(2 * FRAME, 4'hF);

    idle(9, 4'hF);
    loadWait(16'h1234, 4'hF);
    loadWait(16'h5678, 4'hF);
    idle(2 * FRAME, 4'hF);

    idle(2 * FRAME, 4'b1011);

    for (int i = 0; i < 2 * FRAME && (k % FRAME) != 13; i++) applyStimulus(1'b0, 1'b0, 16'h0, 4'hF);
    applyStimulus(1'b0, 1'b1, 16'hC0DE, 4'hF);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'hF);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'hF);
    idle(2 * FRAME, 4'hF);

    loadWait(16'h0050, 4'hF);
    idle(2 * FRAME, 4'hF);
    loadWait(16'h0000, 4'hF);
    idle(2 * FRAME, 4'hF);

    begin
      logic [3:0] en;
      en = 4'hF;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 49) == 0) en = 4'($urandom_range(0, 15));
        applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0,
                      16'($urandom()), en);
      end
    end

    @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain left=%0d expected=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
